master_state_ctrl: RTL and testbench

Top-level game sequencer for the Snake design. It debounces the start button and tracks score and remaining play time. It drives the 2-bit MASTER_STATE that selects what the VGA display state machine shows: idle screen, live game, win animation or lose screen. It also issues a one-cycle GAME_RESET pulse that clears snake and target logic at the start of every game.

---
 rtl/master_pkg.sv | 12 +
 rtl/btn_debounce.sv | 45 ++++
 rtl/master_state_ctrl.sv | 149 ++++++++++++++
 tb/tb_master_state_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/master_pkg.sv
package master_pkg;

  localparam int TIME_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    WIN  = 2'b10,
    LOSE = 2'b11
  } master_state_t;

endpackage

// File: rtl/btn_debounce.sv
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic BTN,
  output logic START_EVT
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] stable_cnt;
  logic          btn_lvl;
  logic          btn_lvl_prev;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_p0      <= 1'b0;
      sync_p1      <= 1'b0;
      stable_cnt   <= '0;
      btn_lvl      <= 1'b0;
      btn_lvl_prev <= 1'b0;
    end else begin
      // stage: two-flop synchroniser
      sync_p0 <= BTN;
      sync_p1 <= sync_p0;
      // stage: debounce, new level accepted after DEBOUNCE_CYCLES differing samples
      if (sync_p1 == btn_lvl) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        btn_lvl    <= sync_p1;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
      // stage: rising-edge detector
      btn_lvl_prev <= btn_lvl;
    end
  end

  assign START_EVT = btn_lvl & ~btn_lvl_prev;

endmodule

// File: rtl/master_state_ctrl.sv
module master_state_ctrl
  import master_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCORE_W         = 4,
  parameter int WIN_SCORE       = 10,
  parameter int TIME_LIMIT      = 60,
  parameter int HOLD_FRAMES     = 180
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               BTN_START,
  input  logic               TARGET_REACHED,
  input  logic               SNAKE_DIED,
  input  logic               FRAME_END,
  output logic [1:0]         MASTER_STATE,
  output logic [SCORE_W-1:0] SCORE,
  output logic [TIME_W-1:0]  TIME_LEFT,
  output logic               GAME_RESET
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  master_state_t      state_q, state_n;
  logic [SCORE_W-1:0] score_q, score_n;
  logic [TIME_W-1:0]  time_q, time_n;
  logic [PW-1:0]      presc_q, presc_n;
  logic [HW-1:0]      hold_q, hold_n;
  logic               grst_q, grst_n;

  logic               start_evt;
  logic               frame_p0;
  logic               frame_p1;
  logic               frame_evt;
  logic               sec_tick;
  logic               win_hit;
  logic [HW-1:0]      hold_inc;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .BTN      (BTN_START),
    .START_EVT(start_evt)
  );

  // stage: frame-end edge detect
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      frame_p0 <= 1'b0;
      frame_p1 <= 1'b0;
    end else begin
      frame_p0 <= FRAME_END;
      frame_p1 <= frame_p0;
    end
  end

  assign frame_evt = frame_p0 & ~frame_p1;
  assign sec_tick  = (presc_q == PW'(CLK_HZ - 1));
  assign win_hit   = (({1'b0, score_q} + (SCORE_W + 1)'(1)) == (SCORE_W + 1)'(WIN_SCORE));
  assign hold_inc  = hold_q + HW'(1);

  // stage: next-state and datapath decode
  always_comb begin
    state_n = state_q;
    score_n = score_q;
    time_n  = time_q;
    presc_n = presc_q;
    hold_n  = hold_q;
    grst_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_evt) begin
          state_n = PLAY;
          score_n = '0;
          time_n  = TIME_W'(TIME_LIMIT);
          presc_n = '0;
          grst_n  = 1'b1;
        end
      end
      PLAY: begin
        presc_n = sec_tick ? '0 : presc_q + PW'(1);
        if (SNAKE_DIED) begin
          state_n = LOSE;
          hold_n  = '0;
        end else begin
          if (TARGET_REACHED) begin
            score_n = sat_inc(score_q);
            if (win_hit) begin
              state_n = WIN;
              hold_n  = '0;
            end
          end
          if (sec_tick) begin
            time_n = time_q - TIME_W'(1);
            // win on the same cycle outranks running out of time
            if (time_q == TIME_W'(1) && state_n == PLAY) begin
              state_n = LOSE;
              hold_n  = '0;
            end
          end
        end
      end
      WIN, LOSE: begin
        if (start_evt) begin
          state_n = IDLE;
        end else if (frame_evt) begin
          hold_n = hold_inc;
          if (hold_inc == HW'(HOLD_FRAMES)) begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // stage: registered state and outputs
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      score_q <= '0;
      time_q  <= '0;
      presc_q <= '0;
      hold_q  <= '0;
      grst_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      score_q <= score_n;
      time_q  <= time_n;
      presc_q <= presc_n;
      hold_q  <= hold_n;
      grst_q  <= grst_n;
    end
  end

  assign MASTER_STATE = state_q;
  assign SCORE        = score_q;
  assign TIME_LEFT    = time_q;
  assign GAME_RESET   = grst_q;

endmodule

// File: tb/tb_master_state_ctrl.sv
module tb_master_state_ctrl;

  logic       CLK;
  logic       RESETN;
  logic       BTN_START;
  logic       TARGET_REACHED;
  logic       SNAKE_DIED;
  logic       FRAME_END;
  logic [1:0] MASTER_STATE;
  logic [3:0] SCORE;
  logic [7:0] TIME_LEFT;
  logic       GAME_RESET;

  int total;
  int bad;

  master_state_ctrl #(
    .CLK_HZ         (10),
    .DEBOUNCE_CYCLES(4),
    .SCORE_W        (4),
    .WIN_SCORE      (3),
    .TIME_LIMIT     (5),
    .HOLD_FRAMES    (2)
  ) dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .BTN_START     (BTN_START),
    .TARGET_REACHED(TARGET_REACHED),
    .SNAKE_DIED    (SNAKE_DIED),
    .FRAME_END     (FRAME_END),
    .MASTER_STATE  (MASTER_STATE),
    .SCORE         (SCORE),
    .TIME_LEFT     (TIME_LEFT),
    .GAME_RESET    (GAME_RESET)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       tr;
    logic       died;
    logic       frame;
    logic [1:0] st;
    int         score;
    int         tl;
  } vec_t;

  vec_t tbl [9];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic start_game();
    int n;
    n = 0;
    BTN_START = 1'b1;
    while (MASTER_STATE != 2'b01 && n < 20) begin
      step();
      n++;
    end
    chk("start_reaches_play", int'(MASTER_STATE), 1);
    chk("start_game_reset", int'(GAME_RESET), 1);
    BTN_START = 1'b0;
  endtask

  task automatic return_idle();
    int n;
    int seen;
    n = 0;
    seen = 0;
    BTN_START = 1'b1;
    while (MASTER_STATE != 2'b00 && n < 20) begin
      step();
      n++;
      if (GAME_RESET) seen = 1;
    end
    chk("press_to_idle", int'(MASTER_STATE), 0);
    BTN_START = 1'b0;
    repeat (10) begin
      step();
      if (GAME_RESET) seen = 1;
    end
    chk("press_no_restart", int'(MASTER_STATE), 0);
    chk("press_no_game_reset", seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int pulses;
    total = 0;
    bad = 0;
    RESETN = 1'b0;
    BTN_START = 1'b0;
    TARGET_REACHED = 1'b0;
    SNAKE_DIED = 1'b0;
    FRAME_END = 1'b0;

    //                tr    died  frame  st     score tl
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'b01, 1, 5};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 2'b01, 1, 5};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 2'b01, 2, 5};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 2'b10, 3, 5};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 2'b10, 3, 5};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 2'b10, 3, 5};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 2'b10, 3, 5};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 2'b10, 3, 5};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 2'b00, 3, 5};

    repeat (3) step();
    chk("reset_state", int'(MASTER_STATE), 0);
    chk("reset_score", int'(SCORE), 0);
    chk("reset_time", int'(TIME_LEFT), 0);
    chk("reset_game_reset", int'(GAME_RESET), 0);
    #2 RESETN = 1'b1;
    repeat (3) step();

    // short glitch must not be accepted
    BTN_START = 1'b1;
    step();
    step();
    BTN_START = 1'b0;
    repeat (10) step();
    chk("glitch_idle", int'(MASTER_STATE), 0);

    // press held for 10 cycles
    first = -1;
    pulses = 0;
    BTN_START = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (GAME_RESET) pulses++;
      if (MASTER_STATE == 2'b01 && first < 0) begin
        first = i;
        chk("grst_at_entry", int'(GAME_RESET), 1);
      end
    end
    BTN_START = 1'b0;
    chk("grst_pulse_count", pulses, 1);
    chk("entry_latency", int'(first >= 6 && first <= 8), 1);
    chk("play_state", int'(MASTER_STATE), 1);
    chk("play_score", int'(SCORE), 0);
    chk("play_time", int'(TIME_LEFT), 5);

    // scoring to WIN, then hold frames back to IDLE
    for (int i = 0; i < 9; i++) begin
      TARGET_REACHED = tbl[i].tr;
      SNAKE_DIED = tbl[i].died;
      FRAME_END = tbl[i].frame;
      step();
      chk($sformatf("vec%0d_state", i), int'(MASTER_STATE), int'(tbl[i].st));
      chk($sformatf("vec%0d_score", i), int'(SCORE), tbl[i].score);
      chk($sformatf("vec%0d_time", i), int'(TIME_LEFT), tbl[i].tl);
      chk($sformatf("vec%0d_grst", i), int'(GAME_RESET), 0);
    end
    TARGET_REACHED = 1'b0;
    SNAKE_DIED = 1'b0;
    FRAME_END = 1'b0;
    repeat (5) step();

    // timeout with no targets
    start_game();
    for (int k = 1; k <= 50; k++) begin
      step();
      chk($sformatf("timeout_t%0d", k), int'(TIME_LEFT), 5 - k / 10);
      chk($sformatf("timeout_s%0d", k), int'(MASTER_STATE), (k < 50) ? 1 : 3);
    end
    chk("timeout_score", int'(SCORE), 0);
    return_idle();

    // death and target on the same cycle
    start_game();
    TARGET_REACHED = 1'b1;
    step();
    step();
    SNAKE_DIED = 1'b1;
    step();
    TARGET_REACHED = 1'b0;
    SNAKE_DIED = 1'b0;
    chk("died_state", int'(MASTER_STATE), 3);
    chk("died_score", int'(SCORE), 2);
    step();
    chk("died_score_frozen", int'(SCORE), 2);
    return_idle();
    chk("idle_keeps_score", int'(SCORE), 2);

    // final target on the last second tick
    start_game();
    TARGET_REACHED = 1'b1;
    step();
    step();
    TARGET_REACHED = 1'b0;
    for (int k = 3; k <= 49; k++) step();
    chk("last_tick_pre_time", int'(TIME_LEFT), 1);
    chk("last_tick_pre_score", int'(SCORE), 2);
    chk("last_tick_pre_state", int'(MASTER_STATE), 1);
    TARGET_REACHED = 1'b1;
    step();
    TARGET_REACHED = 1'b0;
    chk("last_tick_state", int'(MASTER_STATE), 2);
    chk("last_tick_score", int'(SCORE), 3);
    chk("last_tick_time", int'(TIME_LEFT), 0);
    return_idle();
    chk("win_idle_score", int'(SCORE), 3);
    chk("win_idle_time", int'(TIME_LEFT), 0);

    // asynchronous reset in the middle of a game
    start_game();
    TARGET_REACHED = 1'b1;
    step();
    TARGET_REACHED = 1'b0;
    step();
    step();
    chk("mid_pre_score", int'(SCORE), 1);
    #3 RESETN = 1'b0;
    #1;
    chk("async_state", int'(MASTER_STATE), 0);
    chk("async_score", int'(SCORE), 0);
    chk("async_time", int'(TIME_LEFT), 0);
    chk("async_grst", int'(GAME_RESET), 0);
    repeat (2) step();
    #2 RESETN = 1'b1;
    repeat (15) step();
    chk("post_reset_idle", int'(MASTER_STATE), 0);
    chk("post_reset_no_grst", int'(GAME_RESET), 0);
    start_game();
    chk("restart_score", int'(SCORE), 0);
    chk("restart_time", int'(TIME_LEFT), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
